// File: rtl/cat_pkg.sv
// Shared types and the beat-count helper for the cat2 frame controller.
package cat_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } cat_state_t;

  // Number of beats needed to move `elems` elements at `per` elements per beat.
  // Returns 0 when the split is not exact, so the caller can reject it at elaboration.
  function automatic int beats(input int elems, input int per);
    if (per <= 0 || elems <= 0) return 0;
    if (elems % per != 0) return 0;
    return elems / per;
  endfunction

endpackage

// File: rtl/cat_seg_counter.sv
// Saturating 0..N counter with synchronous clear; reports last (N-1) and done (N).
module cat_seg_counter #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          done
);

  always_ff @(posedge clk) begin
    if (!rst)                cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && !done)   cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CW'(N - 1));
  assign done = (cnt == CW'(N));

endmodule

// File: rtl/cat2_frame_ctrl.sv
// Control sequencer for cat2: fills both segments, then drains one concatenated frame.
module cat2_frame_ctrl
  import cat_pkg::*;
#(
  parameter int VecElements0      = 4,
  parameter int ElementsPerWrite0 = 2,
  parameter int VecElements1      = 6,
  parameter int ElementsPerWrite1 = 3,
  parameter int ElementsPerRead   = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_in,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        wr_en0,
  output logic        wr_en1,
  output logic        rd_en,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int W0  = beats(VecElements0, ElementsPerWrite0);
  localparam int W1  = beats(VecElements1, ElementsPerWrite1);
  localparam int R   = beats(VecElements0 + VecElements1, ElementsPerRead);
  localparam int C0W = $clog2(W0 + 1);
  localparam int C1W = $clog2(W1 + 1);
  localparam int CRW = $clog2(R + 1);

  if (W0 == 0 || W1 == 0 || R == 0) begin : g_bad_ratio
    $error("cat2_frame_ctrl: element counts must divide evenly into beats");
  end

  cat_state_t       state, state_nxt;
  logic [C0W-1:0]   cnt0;
  logic [C1W-1:0]   cnt1;
  logic [CRW-1:0]   rcnt;
  logic             last0, last1, rlast;
  logic             done0, done1, rdone;
  logic             cnt_clr;
  logic [15:0]      fcnt;

  // A finished frame and an abort both rewind every counter.
  assign cnt_clr = clear_in | frame_done;

  cat_seg_counter #(.N(W0), .CW(C0W)) u_seg0 (
    .clk(clk_in), .rst(rst_in), .inc(wr_en0), .clr(cnt_clr),
    .cnt(cnt0), .last(last0), .done(done0)
  );

  cat_seg_counter #(.N(W1), .CW(C1W)) u_seg1 (
    .clk(clk_in), .rst(rst_in), .inc(wr_en1), .clr(cnt_clr),
    .cnt(cnt1), .last(last1), .done(done1)
  );

  cat_seg_counter #(.N(R), .CW(CRW)) u_read (
    .clk(clk_in), .rst(rst_in), .inc(rd_en), .clr(cnt_clr),
    .cnt(rcnt), .last(rlast), .done(rdone)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= FILL;
    else         state <= state_nxt;
  end

  // Reset and clear gate every handshake output so nothing moves in those cycles.
  always_comb begin
    state_nxt  = state;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    wr_en0     = 1'b0;
    wr_en1     = 1'b0;
    m_valid    = 1'b0;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    if (rst_in && !clear_in) begin
      case (state)
        FILL: begin
          s0_ready = !done0;
          s1_ready = !done1;
          wr_en0   = s0_valid & s0_ready;
          wr_en1   = s1_valid & s1_ready;
          if ((done0 | (wr_en0 & last0)) && (done1 | (wr_en1 & last1)))
            state_nxt = DRAIN;
        end
        DRAIN: begin
          m_valid = 1'b1;
          rd_en   = m_valid & m_ready;
          if (rd_en && rlast) begin
            frame_done = 1'b1;
            state_nxt  = FILL;
          end
        end
        default: state_nxt = FILL;
      endcase
    end else begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in)         fcnt <= '0;
    else if (frame_done) fcnt <= fcnt + 16'd1;
  end

  assign frame_count = fcnt;
  assign busy = rst_in & ((cnt0 != '0) | (cnt1 != '0) | (rcnt != '0) | rdone |
                          (state == DRAIN));

endmodule

// File: tb/tb_cat2_frame_ctrl.sv
// Directed, table-driven bench for cat2_frame_ctrl at default parameters (W0=W1=R=2).
module tb_cat2_frame_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        clear_in = 1'b0;
  logic        s0_valid = 1'b0;
  logic        s1_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        s0_ready, s1_ready, m_valid, wr_en0, wr_en1, rd_en, frame_done, busy;
  logic [15:0] frame_count;

  cat2_frame_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
    .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_ready(m_ready),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .rd_en(rd_en),
    .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // exp bit order: {s0_ready, s1_ready, m_valid, wr_en0, wr_en1, rd_en, frame_done, busy}
  typedef struct packed {
    logic        rst;
    logic        clr;
    logic        s0v;
    logic        s1v;
    logic        mr;
    logic [7:0]  exp;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   passed = 0;

  task automatic add(input logic rst, input logic clr, input logic s0v, input logic s1v,
                     input logic mr, input logic [7:0] exp, input logic [15:0] fc);
    vec_t v;
    v.rst = rst; v.clr = clr; v.s0v = s0v; v.s1v = s1v; v.mr = mr;
    v.exp = exp; v.fc = fc;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs just after the edge, check outputs mid-cycle.
  task automatic apply(input vec_t v, input string nm);
    logic [7:0] act;
    @(posedge clk_in);
    #1;
    rst_in = v.rst; clear_in = v.clr; s0_valid = v.s0v; s1_valid = v.s1v; m_ready = v.mr;
    @(negedge clk_in);
    act = {s0_ready, s1_ready, m_valid, wr_en0, wr_en1, rd_en, frame_done, busy};
    total++;
    if (act === v.exp) passed++;
    else $display("FAIL %s outputs: got %b expected %b", nm, act, v.exp);
    total++;
    if (frame_count === v.fc) passed++;
    else $display("FAIL %s frame_count: got %0d expected %0d", nm, frame_count, v.fc);
  endtask

  initial begin
    vec_t w;

    // reset held with valids up: everything quiet
    add(0,0,1,1,1, 8'b00000000, 16'd0);
    add(0,0,1,1,1, 8'b00000000, 16'd0);
    // full frame, both producers streaming, consumer always ready
    add(1,0,1,1,1, 8'b11011000, 16'd0);
    add(1,0,1,1,1, 8'b11011001, 16'd0);
    add(1,0,1,1,1, 8'b00100101, 16'd0);
    add(1,0,1,1,1, 8'b00100111, 16'd0);
    add(1,0,0,0,0, 8'b11000000, 16'd1);
    // skewed producers: seg0 done at cycle 1, seg1 writes at 7 and 8
    add(1,0,1,0,0, 8'b11010000, 16'd1);
    add(1,0,1,0,0, 8'b11010001, 16'd1);
    for (int i = 2; i <= 6; i++) add(1,0,1,0,0, 8'b01000001, 16'd1);
    add(1,0,1,1,0, 8'b01001001, 16'd1);
    add(1,0,1,1,0, 8'b01001001, 16'd1);
    // backpressure in DRAIN for 5 cycles, then two accepted beats
    for (int i = 0; i < 5; i++) add(1,0,0,0,0, 8'b00100001, 16'd1);
    add(1,0,0,0,1, 8'b00100101, 16'd1);
    add(1,0,0,0,1, 8'b00100111, 16'd1);
    add(1,0,0,0,0, 8'b11000000, 16'd2);
    // one seg0 beat, then clear with everything offered
    add(1,0,1,0,0, 8'b11010000, 16'd2);
    add(1,1,1,1,1, 8'b00000001, 16'd2);
    add(1,0,0,0,0, 8'b11000000, 16'd2);
    // next frame still needs two beats per segment
    add(1,0,1,1,0, 8'b11011000, 16'd2);
    add(1,0,1,1,0, 8'b11011001, 16'd2);
    add(1,0,0,0,0, 8'b00100001, 16'd2);
    add(1,0,0,0,1, 8'b00100101, 16'd2);
    add(1,0,0,0,1, 8'b00100111, 16'd2);
    add(1,0,0,0,0, 8'b11000000, 16'd3);
    // mid-run reset: outputs gated at once, frame_count cleared by the edge
    add(0,0,1,1,1, 8'b00000000, 16'd3);
    add(1,0,0,0,0, 8'b11000000, 16'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // frame_count wrap: preset to 65535, then drain one more frame
    @(posedge clk_in);
    #1;
    force dut.fcnt = 16'hFFFF;
    w = '{rst:1, clr:0, s0v:0, s1v:0, mr:0, exp:8'b11000000, fc:16'hFFFF};
    apply(w, "wrap_preset");
    release dut.fcnt;
    w = '{rst:1, clr:0, s0v:1, s1v:1, mr:1, exp:8'b11011000, fc:16'hFFFF};
    apply(w, "wrap_w0");
    w.exp = 8'b11011001;
    apply(w, "wrap_w1");
    w.exp = 8'b00100101;
    apply(w, "wrap_r0");
    w.exp = 8'b00100111;
    apply(w, "wrap_r1");
    w = '{rst:1, clr:0, s0v:0, s1v:0, mr:0, exp:8'b11000000, fc:16'h0000};
    apply(w, "wrap_done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
